rm_ctrl_fsm: RTL and testbench

Multi-cycle instruction controller for the RISC datapath. It is the next generation of the WAIT/DECODE/LOAD_A/LOAD_B/LOAD_C/WRITE_OUT controller. It adds LDR/STR with a ready-handshake memory interface, a parametrised memory timeout, HALT, and a sticky error state for undefined opcodes. The block sits between the instruction decoder (opcode/op) and the datapath, register file and memory-address register.

---
 rtl/rm_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_rm_ctrl_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rm_ctrl_fsm.sv
// Multi-cycle instruction controller for the RISC datapath: ALU ops, MOV,
// LDR/STR with a ready-handshake memory port, HALT and a sticky error state.
module rm_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMO_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_rdy,
    output logic [1:0] vsel,
    output logic [2:0] nsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       w,
    output logic       halted,
    output logic       err
);

    localparam logic [3:0] S_WAIT      = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_WRITE_IMM = 4'd2;
    localparam logic [3:0] S_LOAD_A    = 4'd3;
    localparam logic [3:0] S_LOAD_B    = 4'd4;
    localparam logic [3:0] S_LOAD_C    = 4'd5;
    localparam logic [3:0] S_WRITE_OUT = 4'd6;
    localparam logic [3:0] S_ADDR_C    = 4'd7;
    localparam logic [3:0] S_LD_ADDR   = 4'd8;
    localparam logic [3:0] S_MEM_RD    = 4'd9;
    localparam logic [3:0] S_WB_MEM    = 4'd10;
    localparam logic [3:0] S_ST_B      = 4'd11;
    localparam logic [3:0] S_ST_C      = 4'd12;
    localparam logic [3:0] S_MEM_WR    = 4'd13;
    localparam logic [3:0] S_HALT      = 4'd14;
    localparam logic [3:0] S_ERROR     = 4'd15;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_C     = 2'b11;

    localparam logic [2:0] NSEL_RN = 3'b001;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b100;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [TMO_W-1:0] tmo_cnt;

    logic       is_mem_op;
    logic       is_str;
    logic       is_cmp;
    logic       is_asel_op;
    logic       in_mem;
    logic       tmo_hit;

    logic [1:0] vsel_c;
    logic [2:0] nsel_c;
    logic       write_c;
    logic       loada_c;
    logic       loadb_c;
    logic       loadc_c;
    logic       loads_c;
    logic       asel_c;
    logic       bsel_c;
    logic       load_addr_c;
    logic [1:0] mem_cmd_c;
    logic       w_c;
    logic       halted_c;
    logic       err_c;

    assign is_mem_op  = (opcode == 3'b011) || (opcode == 3'b100);
    assign is_str     = (opcode == 3'b100);
    assign is_cmp     = ({opcode, op} == 5'b101_01);
    assign is_asel_op = (opcode == 3'b110) || ({opcode, op} == 5'b101_11);
    assign in_mem     = (state == S_MEM_RD) || (state == S_MEM_WR);
    assign tmo_hit    = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_W'(MEM_TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory wait counter; saturates so MEM_TIMEOUT=0 can wait indefinitely
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (in_mem && !mem_rdy && (state_nxt == state)) begin
            if (tmo_cnt != {TMO_W{1'b1}}) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:      if (s) state_nxt = S_DECODE;
            S_DECODE: begin
                casez ({opcode, op})
                    5'b110_10: state_nxt = S_WRITE_IMM;
                    5'b110_00: state_nxt = S_LOAD_B;
                    5'b101_00,
                    5'b101_10,
                    5'b101_01: state_nxt = S_LOAD_A;
                    5'b101_11: state_nxt = S_LOAD_B;
                    5'b011_00,
                    5'b100_00: state_nxt = S_LOAD_A;
                    5'b111_??: state_nxt = S_HALT;
                    default:   state_nxt = S_ERROR;
                endcase
            end
            S_WRITE_IMM: state_nxt = S_WAIT;
            S_LOAD_A:    state_nxt = is_mem_op ? S_ADDR_C : S_LOAD_B;
            S_LOAD_B:    state_nxt = S_LOAD_C;
            S_LOAD_C:    state_nxt = is_cmp ? S_WAIT : S_WRITE_OUT;
            S_WRITE_OUT: state_nxt = S_WAIT;
            S_ADDR_C:    state_nxt = S_LD_ADDR;
            S_LD_ADDR:   state_nxt = is_str ? S_ST_B : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_rdy)      state_nxt = S_WB_MEM;
                else if (tmo_hit) state_nxt = S_ERROR;
            end
            S_WB_MEM:    state_nxt = S_WAIT;
            S_ST_B:      state_nxt = S_ST_C;
            S_ST_C:      state_nxt = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_rdy)      state_nxt = S_WAIT;
                else if (tmo_hit) state_nxt = S_ERROR;
            end
            S_HALT:      state_nxt = S_HALT;
            S_ERROR:     state_nxt = S_ERROR;
            default:     state_nxt = S_ERROR;
        endcase
    end

    // Output decode of the upcoming state, so registered outputs track state
    always_comb begin
        vsel_c      = VSEL_PC;
        nsel_c      = 3'b000;
        write_c     = 1'b0;
        loada_c     = 1'b0;
        loadb_c     = 1'b0;
        loadc_c     = 1'b0;
        loads_c     = 1'b0;
        asel_c      = 1'b0;
        bsel_c      = 1'b0;
        load_addr_c = 1'b0;
        mem_cmd_c   = CMD_NONE;
        w_c         = 1'b0;
        halted_c    = 1'b0;
        err_c       = 1'b0;
        case (state_nxt)
            S_WAIT:      w_c = 1'b1;
            S_WRITE_IMM: begin vsel_c = VSEL_IMM; nsel_c = NSEL_RN; write_c = 1'b1; end
            S_LOAD_A:    begin nsel_c = NSEL_RN; loada_c = 1'b1; end
            S_LOAD_B:    begin nsel_c = NSEL_RM; loadb_c = 1'b1; end
            S_LOAD_C:    begin loadc_c = 1'b1; loads_c = 1'b1; asel_c = is_asel_op; end
            S_WRITE_OUT: begin vsel_c = VSEL_C; nsel_c = NSEL_RD; write_c = 1'b1; end
            S_ADDR_C:    begin loadc_c = 1'b1; bsel_c = 1'b1; end
            S_LD_ADDR:   load_addr_c = 1'b1;
            S_MEM_RD:    mem_cmd_c = CMD_READ;
            S_WB_MEM:    begin vsel_c = VSEL_MDATA; nsel_c = NSEL_RD; write_c = 1'b1; end
            S_ST_B:      begin nsel_c = NSEL_RD; loadb_c = 1'b1; end
            S_ST_C:      begin loadc_c = 1'b1; asel_c = 1'b1; end
            S_MEM_WR:    mem_cmd_c = CMD_WRITE;
            S_HALT:      halted_c = 1'b1;
            S_ERROR:     err_c = 1'b1;
            default:     ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            vsel      <= VSEL_PC;
            nsel      <= 3'b000;
            write     <= 1'b0;
            loada     <= 1'b0;
            loadb     <= 1'b0;
            loadc     <= 1'b0;
            loads     <= 1'b0;
            asel      <= 1'b0;
            bsel      <= 1'b0;
            load_addr <= 1'b0;
            mem_cmd   <= CMD_NONE;
            w         <= 1'b1;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            vsel      <= vsel_c;
            nsel      <= nsel_c;
            write     <= write_c;
            loada     <= loada_c;
            loadb     <= loadb_c;
            loadc     <= loadc_c;
            loads     <= loads_c;
            asel      <= asel_c;
            bsel      <= bsel_c;
            load_addr <= load_addr_c;
            mem_cmd   <= mem_cmd_c;
            w         <= w_c;
            halted    <= halted_c;
            err       <= err_c;
        end
    end

endmodule

// File: tb/tb_rm_ctrl_fsm.sv
// Scoreboard bench for rm_ctrl_fsm: each driven cycle queues the output
// vector expected after the next clock edge; a monitor pops and compares.
module tb_rm_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       mem_rdy;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel, load_addr;
    logic [1:0] mem_cmd;
    logic       w, halted, err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    rm_ctrl_fsm #(.MEM_TIMEOUT(15), .TMO_W(4)) dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .mem_rdy(mem_rdy), .vsel(vsel), .nsel(nsel), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .load_addr(load_addr), .mem_cmd(mem_cmd),
        .w(w), .halted(halted), .err(err)
    );

    // Vector: {vsel, nsel, write, loada, loadb, loadc, loads, asel, bsel, load_addr, mem_cmd, w, halted, err}
    localparam logic [17:0] E_WAIT = {2'b10, 3'b000, 8'b0000_0000, 2'b00, 3'b100};
    localparam logic [17:0] E_DEC  = {2'b10, 3'b000, 8'b0000_0000, 2'b00, 3'b000};
    localparam logic [17:0] E_WIMM = {2'b01, 3'b001, 8'b1000_0000, 2'b00, 3'b000};
    localparam logic [17:0] E_LA   = {2'b10, 3'b001, 8'b0100_0000, 2'b00, 3'b000};
    localparam logic [17:0] E_LB   = {2'b10, 3'b100, 8'b0010_0000, 2'b00, 3'b000};
    localparam logic [17:0] E_LC0  = {2'b10, 3'b000, 8'b0001_1000, 2'b00, 3'b000};
    localparam logic [17:0] E_LC1  = {2'b10, 3'b000, 8'b0001_1100, 2'b00, 3'b000};
    localparam logic [17:0] E_WO   = {2'b11, 3'b010, 8'b1000_0000, 2'b00, 3'b000};
    localparam logic [17:0] E_ADC  = {2'b10, 3'b000, 8'b0001_0010, 2'b00, 3'b000};
    localparam logic [17:0] E_LDA  = {2'b10, 3'b000, 8'b0000_0001, 2'b00, 3'b000};
    localparam logic [17:0] E_MRD  = {2'b10, 3'b000, 8'b0000_0000, 2'b01, 3'b000};
    localparam logic [17:0] E_WBM  = {2'b00, 3'b010, 8'b1000_0000, 2'b00, 3'b000};
    localparam logic [17:0] E_STB  = {2'b10, 3'b010, 8'b0010_0000, 2'b00, 3'b000};
    localparam logic [17:0] E_STC  = {2'b10, 3'b000, 8'b0001_0100, 2'b00, 3'b000};
    localparam logic [17:0] E_MWR  = {2'b10, 3'b000, 8'b0000_0000, 2'b10, 3'b000};
    localparam logic [17:0] E_HALT = {2'b10, 3'b000, 8'b0000_0000, 2'b00, 3'b010};
    localparam logic [17:0] E_ERR  = {2'b10, 3'b000, 8'b0000_0000, 2'b00, 3'b001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus plus the outputs expected after the next edge
    task automatic cyc(input logic r, input logic si, input logic [2:0] opc,
                       input logic [1:0] o, input logic rdy,
                       input logic [17:0] e, input string tag);
        @(negedge clk);
        reset   = r;
        s       = si;
        opcode  = opc;
        op      = o;
        mem_rdy = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'({vsel, nsel, write, loada, loadb, loadc, loads, asel,
                          bsel, load_addr, mem_cmd, w, halted, err}), 32'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00; mem_rdy = 1'b0;

        // Reset state, reset overriding s, idle with mem_rdy ignored
        cyc(1, 1, 3'b110, 2'b10, 0, E_WAIT, "rst_over_s");
        cyc(0, 0, 3'b110, 2'b10, 1, E_WAIT, "idle_rdy_ign");

        // MOV imm
        cyc(0, 1, 3'b110, 2'b10, 0, E_DEC,  "movi_dec");
        cyc(0, 0, 3'b110, 2'b10, 0, E_WIMM, "movi_wimm");
        cyc(0, 0, 3'b110, 2'b10, 0, E_WAIT, "movi_wait");

        // ADD, with s held high mid-instruction
        cyc(0, 1, 3'b101, 2'b00, 0, E_DEC,  "add_dec");
        cyc(0, 1, 3'b101, 2'b00, 0, E_LA,   "add_la");
        cyc(0, 1, 3'b101, 2'b00, 0, E_LB,   "add_lb");
        cyc(0, 0, 3'b101, 2'b00, 0, E_LC0,  "add_lc");
        cyc(0, 0, 3'b101, 2'b00, 0, E_WO,   "add_wo");
        cyc(0, 0, 3'b101, 2'b00, 0, E_WAIT, "add_wait");

        // CMP: no writeback
        cyc(0, 1, 3'b101, 2'b01, 0, E_DEC,  "cmp_dec");
        cyc(0, 0, 3'b101, 2'b01, 0, E_LA,   "cmp_la");
        cyc(0, 0, 3'b101, 2'b01, 0, E_LB,   "cmp_lb");
        cyc(0, 0, 3'b101, 2'b01, 0, E_LC0,  "cmp_lc");
        cyc(0, 0, 3'b101, 2'b01, 0, E_WAIT, "cmp_wait");

        // MOV reg and MVN: A operand zeroed in LOAD_C
        cyc(0, 1, 3'b110, 2'b00, 0, E_DEC,  "movr_dec");
        cyc(0, 0, 3'b110, 2'b00, 0, E_LB,   "movr_lb");
        cyc(0, 0, 3'b110, 2'b00, 0, E_LC1,  "movr_lc");
        cyc(0, 0, 3'b110, 2'b00, 0, E_WO,   "movr_wo");
        cyc(0, 0, 3'b110, 2'b00, 0, E_WAIT, "movr_wait");
        cyc(0, 1, 3'b101, 2'b11, 0, E_DEC,  "mvn_dec");
        cyc(0, 0, 3'b101, 2'b11, 0, E_LB,   "mvn_lb");
        cyc(0, 0, 3'b101, 2'b11, 0, E_LC1,  "mvn_lc");
        cyc(0, 0, 3'b101, 2'b11, 0, E_WO,   "mvn_wo");
        cyc(0, 0, 3'b101, 2'b11, 0, E_WAIT, "mvn_wait");

        // LDR, mem_rdy arriving 3 cycles after MEM_RD entry
        cyc(0, 1, 3'b011, 2'b00, 0, E_DEC,  "ldr_dec");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LA,   "ldr_la");
        cyc(0, 0, 3'b011, 2'b00, 0, E_ADC,  "ldr_adc");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LDA,  "ldr_lda");
        cyc(0, 0, 3'b011, 2'b00, 1, E_MRD,  "ldr_mrd0");
        for (int i = 0; i < 3; i++) cyc(0, 0, 3'b011, 2'b00, 0, E_MRD, "ldr_mrd_hold");
        cyc(0, 0, 3'b011, 2'b00, 1, E_WBM,  "ldr_wbm");
        cyc(0, 0, 3'b011, 2'b00, 0, E_WAIT, "ldr_wait");

        // LDR where mem_rdy lands exactly on the timeout cycle
        cyc(0, 1, 3'b011, 2'b00, 0, E_DEC,  "ldrb_dec");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LA,   "ldrb_la");
        cyc(0, 0, 3'b011, 2'b00, 0, E_ADC,  "ldrb_adc");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LDA,  "ldrb_lda");
        cyc(0, 0, 3'b011, 2'b00, 0, E_MRD,  "ldrb_mrd0");
        for (int i = 0; i < 15; i++) cyc(0, 0, 3'b011, 2'b00, 0, E_MRD, "ldrb_mrd_hold");
        cyc(0, 0, 3'b011, 2'b00, 1, E_WBM,  "ldrb_rdy_wins");
        cyc(0, 0, 3'b011, 2'b00, 0, E_WAIT, "ldrb_wait");

        // STR with immediate ready
        cyc(0, 1, 3'b100, 2'b00, 0, E_DEC,  "str_dec");
        cyc(0, 0, 3'b100, 2'b00, 0, E_LA,   "str_la");
        cyc(0, 0, 3'b100, 2'b00, 0, E_ADC,  "str_adc");
        cyc(0, 0, 3'b100, 2'b00, 0, E_LDA,  "str_lda");
        cyc(0, 0, 3'b100, 2'b00, 0, E_STB,  "str_stb");
        cyc(0, 0, 3'b100, 2'b00, 0, E_STC,  "str_stc");
        cyc(0, 0, 3'b100, 2'b00, 0, E_MWR,  "str_mwr");
        cyc(0, 0, 3'b100, 2'b00, 1, E_WAIT, "str_wait");

        // STR timeout: 16 cycles of write command, then sticky ERROR
        cyc(0, 1, 3'b100, 2'b00, 0, E_DEC,  "strt_dec");
        cyc(0, 0, 3'b100, 2'b00, 0, E_LA,   "strt_la");
        cyc(0, 0, 3'b100, 2'b00, 0, E_ADC,  "strt_adc");
        cyc(0, 0, 3'b100, 2'b00, 0, E_LDA,  "strt_lda");
        cyc(0, 0, 3'b100, 2'b00, 0, E_STB,  "strt_stb");
        cyc(0, 0, 3'b100, 2'b00, 0, E_STC,  "strt_stc");
        cyc(0, 0, 3'b100, 2'b00, 0, E_MWR,  "strt_mwr0");
        for (int i = 0; i < 15; i++) cyc(0, 0, 3'b100, 2'b00, 0, E_MWR, "strt_mwr_hold");
        cyc(0, 0, 3'b100, 2'b00, 0, E_ERR,  "strt_timeout");
        for (int i = 0; i < 4; i++) cyc(0, i[0], 3'b110, 2'b10, 1, E_ERR, "err_sticky");
        cyc(1, 0, 3'b110, 2'b10, 0, E_WAIT, "err_reset");

        // HALT, s pulsed for 20 cycles
        cyc(0, 1, 3'b111, 2'b01, 0, E_DEC,  "halt_dec");
        cyc(0, 0, 3'b111, 2'b01, 0, E_HALT, "halt_enter");
        for (int i = 0; i < 20; i++) cyc(0, i[0], 3'b111, 2'b01, 0, E_HALT, "halt_sticky");
        cyc(1, 0, 3'b111, 2'b01, 0, E_WAIT, "halt_reset");

        // Undefined opcodes
        cyc(0, 1, 3'b000, 2'b00, 0, E_DEC,  "undef_dec");
        cyc(0, 0, 3'b000, 2'b00, 0, E_ERR,  "undef_err");
        cyc(0, 1, 3'b000, 2'b00, 0, E_ERR,  "undef_sticky");
        cyc(1, 0, 3'b000, 2'b00, 0, E_WAIT, "undef_reset");
        cyc(0, 1, 3'b110, 2'b01, 0, E_DEC,  "undef2_dec");
        cyc(0, 0, 3'b110, 2'b01, 0, E_ERR,  "undef2_err");
        cyc(1, 0, 3'b110, 2'b01, 0, E_WAIT, "undef2_reset");

        // Reset in the middle of MEM_RD
        cyc(0, 1, 3'b011, 2'b00, 0, E_DEC,  "rmid_dec");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LA,   "rmid_la");
        cyc(0, 0, 3'b011, 2'b00, 0, E_ADC,  "rmid_adc");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LDA,  "rmid_lda");
        cyc(0, 0, 3'b011, 2'b00, 0, E_MRD,  "rmid_mrd");
        cyc(0, 0, 3'b011, 2'b00, 0, E_MRD,  "rmid_mrd1");
        cyc(1, 1, 3'b011, 2'b00, 1, E_WAIT, "rmid_reset");
        cyc(0, 0, 3'b011, 2'b00, 0, E_WAIT, "rmid_idle");
        // Timeout counter must have been cleared by that reset
        cyc(0, 1, 3'b011, 2'b00, 0, E_DEC,  "rmid2_dec");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LA,   "rmid2_la");
        cyc(0, 0, 3'b011, 2'b00, 0, E_ADC,  "rmid2_adc");
        cyc(0, 0, 3'b011, 2'b00, 0, E_LDA,  "rmid2_lda");
        cyc(0, 0, 3'b011, 2'b00, 0, E_MRD,  "rmid2_mrd0");
        for (int i = 0; i < 15; i++) cyc(0, 0, 3'b011, 2'b00, 0, E_MRD, "rmid2_mrd_hold");
        cyc(0, 0, 3'b011, 2'b00, 0, E_ERR,  "rmid2_timeout");

        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
